// File: rtl/mvu_stream_output_block_pkg.sv
// Shared definitions for the MVU stream control blocks.
// Contents:
//   out_state_t - output FIFO fill state (EMPTY / PARTIAL / FULL)
//   clog2_min1  - ceil(log2(n)) clamped to at least 1, for counter and
//                 pointer widths that must stay legal when n == 1
package mvu_stream_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } out_state_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mvu_stream_output_block_if.sv
// Output stream bundle of the MVU: valid/ready handshake with a PE-wide
// data vector and a last-bank tag.
// Signals:
//   out_v    - beat valid (driven by master)
//   out_data - PE*ACC_W beat payload, PE0 in the LSBs (driven by master)
//   out_last - beat belongs to the final filter bank (driven by master)
//   rready   - consumer ready (driven by slave)
interface mvu_stream_output_block_if #(
    parameter int PE    = 4,
    parameter int ACC_W = 16
);
    logic                  out_v;
    logic [PE*ACC_W-1:0]   out_data;
    logic                  out_last;
    logic                  rready;

    modport master (output out_v, output out_data, output out_last, input rready);
    modport slave  (input out_v, input out_data, input out_last, output rready);
endinterface

// File: rtl/mvu_stream_output_block_fifo.sv
// Small output FIFO: DEPTH entries of W bits with wrap-around read/write
// pointers. Written on push, head presented combinationally from the
// register array. The array is cleared on reset so the head is all zeros
// right after reset.
// Ports:
//   clock, resetn - clock and asynchronous active-low reset
//   push, wr_data - write strobe and entry to append
//   pop           - advance the read pointer
//   rd_data       - current head entry
module mvu_stream_out_fifo
    import mvu_stream_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 65
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data
);
    localparam int PTR_W = clog2_min1(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Non-power-of-two depths need an explicit wrap rather than overflow.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_IDX) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Storage array and pointer registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/mvu_stream_output_block.sv
// Transmit-side controller of the MVU stream. Captures the PE accumulator
// vector at the end of every SF pass, buffers it in a small FIFO and drives
// the output valid/ready stream, tagging beats of the last filter bank.
// Ports:
//   clock, resetn - clock and asynchronous active-low reset
//   acc_v         - one-cycle pulse: accumulator vector complete
//   acc_data      - accumulator vector, PE0 in the LSBs
//   stream        - output stream (out_v/out_data/out_last out, rready in)
//   wait_rready   - head is valid but the consumer is stalling (combinational)
//   ovf_err       - sticky: a result arrived while the FIFO had no room
//   occupancy     - number of entries currently buffered
module mvu_stream_output_block
    import mvu_stream_pkg::*;
#(
    parameter int PE    = 4,
    parameter int ACC_W = 16,
    parameter int NF    = 2,
    parameter int DEPTH = 2,
    parameter int CNT_T = $clog2(DEPTH + 1),
    parameter int NF_T  = clog2_min1(NF)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     acc_v,
    input  logic [PE*ACC_W-1:0]      acc_data,
    mvu_stream_output_block_if.master stream,
    output logic                     wait_rready,
    output logic                     ovf_err,
    output logic [CNT_T-1:0]         occupancy
);
    localparam int DW = PE * ACC_W;
    localparam logic [CNT_T-1:0] DEPTH_C  = CNT_T'(DEPTH);
    localparam logic [CNT_T-1:0] DEPTH_M1 = CNT_T'(DEPTH - 1);
    localparam logic [CNT_T-1:0] ONE_C    = CNT_T'(1);
    localparam logic [NF_T-1:0]  NF_LAST  = NF_T'(NF - 1);

    out_state_t      state;
    out_state_t      state_next;
    logic            out_v_q;
    logic [NF_T-1:0] nf_wr;
    logic            push;
    logic            pop;
    logic            drop;
    logic [DW:0]     head;
    logic [DW:0]     wr_entry;

    // A full FIFO can still accept when the head leaves in the same cycle.
    assign pop      = out_v_q & stream.rready;
    assign push     = acc_v & ((occupancy < DEPTH_C) | pop);
    assign drop     = acc_v & ~push;
    assign wr_entry = {(nf_wr == NF_LAST), acc_data};

    mvu_stream_out_fifo #(
        .DEPTH (DEPTH),
        .W     (DW + 1)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head)
    );

    // Next fill state from the push/pop pair and current occupancy.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = PARTIAL;
                end else begin
                    state_next = EMPTY;
                end
            end
            PARTIAL: begin
                if (push && !pop && (occupancy == DEPTH_M1)) begin
                    state_next = FULL;
                end else if (pop && !push && (occupancy == ONE_C)) begin
                    state_next = EMPTY;
                end else begin
                    state_next = PARTIAL;
                end
            end
            FULL: begin
                if (pop && !push) begin
                    state_next = PARTIAL;
                end else begin
                    state_next = FULL;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Fill state plus a dedicated out_v flop so the valid line never
    // depends on decoding the state bits.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= EMPTY;
            out_v_q <= 1'b0;
        end else begin
            state   <= state_next;
            out_v_q <= (state_next != EMPTY);
        end
    end

    // Occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            occupancy <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occupancy <= occupancy + ONE_C;
                2'b01:   occupancy <= occupancy - ONE_C;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Filter-bank counter advances only on accepted beats; dropped beats
    // must not shift the last-bank tagging.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            nf_wr <= '0;
        end else if (push) begin
            if (nf_wr == NF_LAST) begin
                nf_wr <= '0;
            end else begin
                nf_wr <= nf_wr + NF_T'(1);
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf_err <= 1'b0;
        end else if (drop) begin
            ovf_err <= 1'b1;
        end
    end

    assign stream.out_v    = out_v_q;
    assign stream.out_data = head[DW-1:0];
    // Gated so a stale tag in an emptied slot never shows on an idle bus.
    assign stream.out_last = out_v_q & head[DW];
    assign wait_rready     = out_v_q & ~stream.rready;

endmodule

// File: tb/tb_mvu_stream_output_block.sv
// Self-checking bench for mvu_stream_output_block (PE=4, ACC_W=16, NF=2,
// DEPTH=2). A reference process queues every beat the block should accept;
// a monitor pops and compares on each output handshake and checks
// valid/occupancy/overflow/stall flags and head stability every cycle.
module tb_mvu_stream_output_block;
    import mvu_stream_pkg::*;

    localparam int PE    = 4;
    localparam int ACC_W = 16;
    localparam int NF    = 2;
    localparam int DEPTH = 2;
    localparam int DW    = PE * ACC_W;
    localparam int CNT_T = $clog2(DEPTH + 1);

    typedef logic [DW:0] beat_t;

    logic             clock    = 1'b0;
    logic             resetn   = 1'b0;
    logic             acc_v    = 1'b0;
    logic [DW-1:0]    acc_data = '0;
    logic             wait_rready;
    logic             ovf_err;
    logic [CNT_T-1:0] occupancy;

    mvu_stream_output_block_if #(.PE(PE), .ACC_W(ACC_W)) stream ();

    mvu_stream_output_block #(
        .PE    (PE),
        .ACC_W (ACC_W),
        .NF    (NF),
        .DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .acc_v       (acc_v),
        .acc_data    (acc_data),
        .stream      (stream.master),
        .wait_rready (wait_rready),
        .ovf_err     (ovf_err),
        .occupancy   (occupancy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input beat_t act, input beat_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected beat queue, fill level, bank counter, overflow.
    beat_t q[$];
    int    m_occ = 0;
    int    m_nf  = 0;
    logic  m_ovf = 1'b0;

    initial forever begin
        logic p;
        logic ps;
        @(posedge clock or negedge resetn);
        if (!resetn) begin
            q.delete();
            m_occ = 0;
            m_nf  = 0;
            m_ovf = 1'b0;
        end else begin
            p  = (m_occ > 0) && stream.rready;
            ps = acc_v && ((m_occ < DEPTH) || p);
            if (acc_v && !ps) m_ovf = 1'b1;
            if (ps) begin
                q.push_back({(m_nf == NF - 1), acc_data});
                m_nf = (m_nf == NF - 1) ? 0 : m_nf + 1;
            end
            m_occ = m_occ + (ps ? 1 : 0) - (p ? 1 : 0);
        end
    end

    // Monitor: sampled on the falling edge.
    beat_t prev_beat  = '0;
    logic  prev_stall = 1'b0;
    int    pops       = 0;
    int    lasts      = 0;

    initial forever begin
        @(negedge clock);
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            check("out_v", beat_t'(stream.out_v), beat_t'(m_occ != 0));
            check("occupancy", beat_t'(occupancy), beat_t'(m_occ));
            check("ovf_err", beat_t'(ovf_err), beat_t'(m_ovf));
            check("wait_rready", beat_t'(wait_rready),
                  beat_t'((m_occ != 0) && !stream.rready));
            if (prev_stall) begin
                check("stable", {stream.out_last, stream.out_data}, prev_beat);
            end
            if (stream.out_v && stream.rready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat: got %0h expected no beat at %0t",
                             stream.out_data, $time);
                end else begin
                    check("beat", {stream.out_last, stream.out_data}, q.pop_front());
                    pops++;
                    if (stream.out_last) lasts++;
                end
            end
            prev_stall = stream.out_v && !stream.rready;
            prev_beat  = {stream.out_last, stream.out_data};
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic [DW-1:0] d);
        acc_v    = 1'b1;
        acc_data = d;
        tick();
        acc_v    = 1'b0;
    endtask

    localparam logic [DW-1:0] D1 = 64'h0004_0003_0002_0001;
    localparam logic [DW-1:0] D2 = 64'h1111_2222_3333_4444;
    localparam logic [DW-1:0] D3 = 64'h5555_6666_7777_8888;
    localparam logic [DW-1:0] DA = 64'hAAAA_0000_AAAA_0001;
    localparam logic [DW-1:0] DB = 64'hBBBB_0000_BBBB_0002;
    localparam logic [DW-1:0] DC = 64'hCCCC_0000_CCCC_0003;
    localparam logic [DW-1:0] DD = 64'hDDDD_0000_DDDD_0004;

    initial begin
        int issued;
        stream.rready = 1'b0;

        // Reset held for three cycles.
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_v", beat_t'(stream.out_v), beat_t'(0));
        check("rst_occ", beat_t'(occupancy), beat_t'(0));
        check("rst_wait", beat_t'(wait_rready), beat_t'(0));
        check("rst_ovf", beat_t'(ovf_err), beat_t'(0));
        check("rst_last", beat_t'(stream.out_last), beat_t'(0));
        check("rst_data", beat_t'(stream.out_data), beat_t'(0));
        resetn = 1'b1;
        tick();

        // Asynchronous reset with one entry held.
        pulse(D3);
        check("mid_occ_before", beat_t'(occupancy), beat_t'(1));
        #2;
        resetn = 1'b0;
        #1;
        check("mid_out_v", beat_t'(stream.out_v), beat_t'(0));
        check("mid_occ", beat_t'(occupancy), beat_t'(0));
        check("mid_data", beat_t'(stream.out_data), beat_t'(0));
        tick();
        resetn = 1'b1;
        tick();

        // Single beats with the consumer ready: bank tags 0, 1, 0.
        stream.rready = 1'b1;
        pulse(D1);
        check("single_v", beat_t'(stream.out_v), beat_t'(1));
        check("single_data", beat_t'(stream.out_data), beat_t'(D1));
        check("single_last0", beat_t'(stream.out_last), beat_t'(0));
        pulse(D2);
        check("second_data", beat_t'(stream.out_data), beat_t'(D2));
        check("second_last1", beat_t'(stream.out_last), beat_t'(1));
        pulse(D3);
        check("third_last0", beat_t'(stream.out_last), beat_t'(0));
        tick();
        check("single_idle", beat_t'(stream.out_v), beat_t'(0));

        // Backpressure: fill to FULL, then drain A then B. nf_wr is 1 here.
        stream.rready = 1'b0;
        pulse(DA);
        pulse(DB);
        check("bp_occ", beat_t'(occupancy), beat_t'(2));
        check("bp_state", beat_t'(dut.state), beat_t'(FULL));
        check("bp_wait", beat_t'(wait_rready), beat_t'(1));
        check("bp_head", beat_t'(stream.out_data), beat_t'(DA));
        check("bp_head_last", beat_t'(stream.out_last), beat_t'(1));
        stream.rready = 1'b1;
        tick();
        check("bp_second", beat_t'(stream.out_data), beat_t'(DB));
        tick();
        check("bp_done", beat_t'(stream.out_v), beat_t'(0));

        // Simultaneous push and pop while FULL. A:last1 B:last0 C:last1.
        stream.rready = 1'b0;
        pulse(DA);
        pulse(DB);
        check("sim_full", beat_t'(dut.state), beat_t'(FULL));
        acc_v         = 1'b1;
        acc_data      = DC;
        stream.rready = 1'b1;
        tick();
        acc_v = 1'b0;
        check("sim_occ", beat_t'(occupancy), beat_t'(2));
        check("sim_ovf", beat_t'(ovf_err), beat_t'(0));
        check("sim_state", beat_t'(dut.state), beat_t'(FULL));
        check("sim_head", beat_t'(stream.out_data), beat_t'(DB));
        tick();
        check("sim_c", beat_t'(stream.out_data), beat_t'(DC));
        check("sim_c_last", beat_t'(stream.out_last), beat_t'(1));
        tick();
        check("sim_done", beat_t'(stream.out_v), beat_t'(0));

        // Overflow: C dropped while FULL. A:last0 B:last1, then D:last0.
        stream.rready = 1'b0;
        pulse(DA);
        pulse(DB);
        pulse(DC);
        check("ovf_set", beat_t'(ovf_err), beat_t'(1));
        check("ovf_occ", beat_t'(occupancy), beat_t'(2));
        check("ovf_head", beat_t'(stream.out_data), beat_t'(DA));
        tick();
        check("ovf_sticky", beat_t'(ovf_err), beat_t'(1));
        stream.rready = 1'b1;
        tick();
        check("ovf_b", beat_t'(stream.out_data), beat_t'(DB));
        tick();
        check("ovf_empty", beat_t'(stream.out_v), beat_t'(0));
        stream.rready = 1'b0;
        pulse(DD);
        check("ovf_next_data", beat_t'(stream.out_data), beat_t'(DD));
        check("ovf_next_last", beat_t'(stream.out_last), beat_t'(0));
        check("ovf_still", beat_t'(ovf_err), beat_t'(1));
        stream.rready = 1'b1;
        tick();

        // Random stall soak: 1000 accepted beats, rready about 50%.
        pops   = 0;
        lasts  = 0;
        issued = 0;
        for (int cyc = 0; cyc < 20000 && issued < 1000; cyc++) begin
            stream.rready = 1'($urandom_range(0, 1));
            if (m_occ < DEPTH && $urandom_range(0, 1) == 1) begin
                acc_v    = 1'b1;
                acc_data = {$urandom(), $urandom()};
                issued++;
            end else begin
                acc_v = 1'b0;
            end
            tick();
        end
        acc_v         = 1'b0;
        stream.rready = 1'b1;
        repeat (DEPTH + 2) tick();
        check("soak_pops", beat_t'(pops), beat_t'(1000));
        check("soak_lasts", beat_t'(lasts), beat_t'(500));
        check("soak_q_empty", beat_t'(q.size()), beat_t'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
